tdc_pulsegen: RTL and testbench



---
 rtl/tdc_pulsegen.sv | 197 +++++++++++++++++++
 tb/tb_tdc_pulsegen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_pulsegen.sv
// Wishbone-programmable pulse-train generator used as TDC self-test / code-density stimulus.
// Optional LFSR jitter on the low phase is built when TDC_PULSEGEN_JITTER_EN is defined.
module tdc_pulsegen #(
  parameter int g_WIDTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_irq_o,
  output logic        pulse_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [g_WIDTH-1:0] cnt_q, cnt_d;
  logic [g_WIDTH-1:0] high_q, high_d, low_q, low_d, count_q, count_d;
  logic [g_WIDTH-1:0] sent_q, sent_d, tgt_q, tgt_d;
  logic               pulse_q, pulse_d, done_q, done_d, irq_en_q, irq_en_d;
  logic               ack_q, ack_d;
  logic [31:0]        data_q, data_d, rd_val;
  logic [g_WIDTH-1:0] jitter, hi_load, lo_load, sent_inc;
  logic               bus_req, wr_en, wr_ctrl, start_cmd, stop_cmd;

  // Replace only the byte lanes selected by the bus.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  assign bus_req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en     = bus_req & wb_we_i;
  assign wr_ctrl   = wr_en && (wb_addr_i == 4'd0) && wb_sel_i[0];
  assign start_cmd = wr_ctrl & wb_data_i[0];
  assign stop_cmd  = wr_ctrl & wb_data_i[1];

`ifdef TDC_PULSEGEN_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d, jmask_q, jmask_d;
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign jitter = g_WIDTH'(lfsr_q & jmask_q);
  assign jmask_d = (wr_en && wb_addr_i == 4'd5) ?
                   16'(merge_lanes(32'(jmask_q), wb_data_i, wb_sel_i)) : jmask_q;

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      lfsr_q  <= 16'hACE1;
      jmask_q <= 16'h0000;
    end else begin
      lfsr_q  <= lfsr_d;
      jmask_q <= jmask_d;
    end
  end
`else
  assign jitter = '0;
`endif

  assign hi_load  = (high_q == '0) ? '0 : high_q - g_WIDTH'(1);
  assign lo_load  = ((low_q == '0) ? '0 : low_q - g_WIDTH'(1)) + jitter;
  assign sent_inc = sent_q + g_WIDTH'(1);

  always_comb begin
    rd_val = '0;
    case (wb_addr_i)
      4'd0: rd_val = {28'd0, done_q, irq_en_q, 1'b0, state_q != ST_IDLE};
      4'd1: rd_val = 32'(high_q);
      4'd2: rd_val = 32'(low_q);
      4'd3: rd_val = 32'(count_q);
      4'd4: rd_val = 32'(sent_q);
`ifdef TDC_PULSEGEN_JITTER_EN
      4'd5: rd_val = 32'(jmask_q);
`endif
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    ack_d    = bus_req;
    data_d   = (bus_req && !wb_we_i) ? rd_val : '0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = pulse_q;
    sent_d   = sent_q;
    tgt_d    = tgt_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    high_d   = high_q;
    low_d    = low_q;
    count_d  = count_q;

    if (wr_ctrl) begin
      irq_en_d = wb_data_i[2];
      if (wb_data_i[3]) done_d = 1'b0;
    end
    if (wr_en && wb_addr_i == 4'd1) high_d  = g_WIDTH'(merge_lanes(32'(high_q), wb_data_i, wb_sel_i));
    if (wr_en && wb_addr_i == 4'd2) low_d   = g_WIDTH'(merge_lanes(32'(low_q), wb_data_i, wb_sel_i));
    if (wr_en && wb_addr_i == 4'd3) count_d = g_WIDTH'(merge_lanes(32'(count_q), wb_data_i, wb_sel_i));

    // FSM transitions come after the clear so that a DONE set wins the same edge.
    case (state_q)
      ST_IDLE: begin
        if (start_cmd && !stop_cmd) begin
          tgt_d   = count_q;
          sent_d  = '0;
          done_d  = 1'b0;
          state_d = ST_HIGH;
          cnt_d   = hi_load;
          pulse_d = 1'b1;
        end
      end
      ST_HIGH: begin
        if (stop_cmd) begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - g_WIDTH'(1);
        end else begin
          sent_d  = sent_inc;
          pulse_d = 1'b0;
          if (tgt_q != '0 && sent_inc == tgt_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOW;
            cnt_d   = lo_load;
          end
        end
      end
      ST_LOW: begin
        if (stop_cmd) begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - g_WIDTH'(1);
        end else begin
          state_d = ST_HIGH;
          cnt_d   = hi_load;
          pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      sent_q   <= '0;
      tgt_q    <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      sent_q   <= sent_d;
      tgt_q    <= tgt_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      high_q   <= high_d;
      low_q    <= low_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_data_o = data_q;
  assign wb_irq_o  = done_q & irq_en_q;
  assign pulse_o   = pulse_q;

endmodule

// File: tb/tb_tdc_pulsegen.sv
// Directed + randomized bench for tdc_pulsegen against an arithmetic pulse-train model.
// Jitter checks are compiled in when TDC_PULSEGEN_JITTER_EN is defined.
module tb_tdc_pulsegen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic        ack, irq, pulse;
  int          checks = 0;
  int          errors = 0;

  tdc_pulsegen #(.g_WIDTH(16)) dut (
    .wb_clk_i(clk), .rst_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wdat), .wb_data_o(rdat),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel), .wb_ack_o(ack),
    .wb_irq_o(irq), .pulse_o(pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each bus task returns at the falling edge right after the commit edge.
  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdat = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    chk("wr_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("WR addr=%0d data=0x%08h sel=%b", a, d, s);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("rd_ack", {31'd0, ack}, 32'd1);
    d = rdat;
    cyc = 1'b0; stb = 1'b0;
    $display("RD addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    wb_read(a, v);
    chk(tag, v, exp);
  endtask

  // Pulse level k cycles after the START commit edge, from the phase-length rules.
  function automatic logic exp_pulse(int k, int h, int l, int n);
    int hh = (h == 0) ? 1 : h;
    int ll = (l == 0) ? 1 : l;
    int per = hh + ll;
    if (n != 0 && k >= n * per - ll) return 1'b0;
    return (k % per) < hh;
  endfunction

  function automatic logic exp_irq(int k, int h, int l, int n, bit ien);
    int hh = (h == 0) ? 1 : h;
    int ll = (l == 0) ? 1 : l;
    return ien && n != 0 && k >= n * (hh + ll) - ll;
  endfunction

  // Caller is positioned at sample index 'from' (relative to the START commit edge).
  task automatic check_train(input int h, input int l, input int n, input bit ien,
                             input int from, input int to);
    for (int k = from; k <= to; k++) begin
      if (k != from) @(negedge clk);
      chk($sformatf("pulse[%0d]", k), {31'd0, pulse}, {31'd0, exp_pulse(k, h, l, n)});
      chk($sformatf("irq[%0d]", k), {31'd0, irq}, {31'd0, exp_irq(k, h, l, n, ien)});
    end
    $display("TRAIN h=%0d l=%0d n=%0d ien=%0d samples %0d..%0d", h, l, n, ien, from, to);
  endtask

`ifdef TDC_PULSEGEN_JITTER_EN
  task automatic measure_lows(input int lo, input int hi, output int distinct);
    int run = 0;
    int nlows = 0;
    logic [15:0] seen = '0;
    for (int c = 0; c < 2000 && nlows < 99; c++) begin
      @(negedge clk);
      if (pulse === 1'b0) run++;
      else if (run > 0) begin
        nlows++;
        chk("jit_low_range", {31'd0, (run >= lo && run <= hi)}, 32'd1);
        if (run < 16) seen[run] = 1'b1;
        run = 0;
      end
    end
    chk("jit_nlows", nlows, 99);
    distinct = $countones(seen);
    $display("JITTER lows=%0d distinct=%0d", nlows, distinct);
  endtask
`endif

  initial begin
    logic [31:0] v;
    int h, l, n;
    bit ien;

    // Reset and idle readback
    repeat (3) @(negedge clk);
    chk("rst_pulse", {31'd0, pulse}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_data", rdat, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) rd_chk($sformatf("rst_reg%0d", a), 4'(a), 32'd0);

    // Ack is one cycle high then forced low while the strobe stays asserted
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ack_pat%0d", i), {31'd0, ack}, {31'd0, (i % 2 == 0)});
    end
    cyc = 1'b0; stb = 1'b0;

    // HIGH=3 LOW=2 COUNT=2 with interrupt
    wb_write(4'd1, 32'd3, 4'hF);
    wb_write(4'd2, 32'd2, 4'hF);
    wb_write(4'd3, 32'd2, 4'hF);
    wb_write(4'd0, 32'h5, 4'hF);
    check_train(3, 2, 2, 1'b1, 0, 12);
    rd_chk("t1_sent", 4'd4, 32'd2);
    rd_chk("t1_ctrl_done", 4'd0, 32'hC);
    wb_write(4'd0, 32'hC, 4'hF);
    chk("t1_irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("t1_ctrl_clr", 4'd0, 32'h4);

    // Continuous toggle, stopped mid-train
    wb_write(4'd1, 32'd0, 4'hF);
    wb_write(4'd2, 32'd0, 4'hF);
    wb_write(4'd3, 32'd0, 4'hF);
    wb_write(4'd0, 32'h1, 4'hF);
    check_train(0, 0, 0, 1'b0, 0, 9);
    wb_write(4'd0, 32'h2, 4'hF);
    chk("cont_stop_pulse", {31'd0, pulse}, 32'd0);
    rd_chk("cont_ctrl", 4'd0, 32'h8);
    rd_chk("cont_sent", 4'd4, 32'd5);

    // START and COUNT written while busy do not disturb the current run
    wb_write(4'd1, 32'd4, 4'hF);
    wb_write(4'd2, 32'd4, 4'hF);
    wb_write(4'd3, 32'd3, 4'hF);
    wb_write(4'd0, 32'h1, 4'hF);
    wb_write(4'd0, 32'h1, 4'hF);
    wb_write(4'd3, 32'd9, 4'hF);
    check_train(4, 4, 3, 1'b0, 4, 24);
    rd_chk("busy_sent", 4'd4, 32'd3);
    wb_write(4'd0, 32'h1, 4'hF);
    check_train(4, 4, 9, 1'b0, 0, 70);
    rd_chk("next_sent", 4'd4, 32'd9);

    // Randomized finite trains against the model
    for (int it = 0; it < 6; it++) begin
      h = $urandom_range(0, 5);
      l = $urandom_range(0, 5);
      n = $urandom_range(1, 5);
      ien = 1'($urandom_range(0, 1));
      wb_write(4'd1, 32'(h), 4'hF);
      wb_write(4'd2, 32'(l), 4'hF);
      wb_write(4'd3, 32'(n), 4'hF);
      wb_write(4'd0, {29'd0, ien, 2'b01}, 4'hF);
      check_train(h, l, n, ien, 0, n * ((h == 0 ? 1 : h) + (l == 0 ? 1 : l)) + 2);
      rd_chk("rnd_sent", 4'd4, 32'(n));
      rd_chk("rnd_ctrl", 4'd0, {28'd0, 1'b1, ien, 2'b00});
      wb_write(4'd0, 32'h8, 4'hF);
      chk("rnd_irq_clr", {31'd0, irq}, 32'd0);
    end

    // START+STOP together in IDLE: nothing happens, DONE stays clear
    wb_write(4'd0, 32'h3, 4'hF);
    chk("ss_pulse", {31'd0, pulse}, 32'd0);
    rd_chk("ss_ctrl", 4'd0, 32'h0);

    // Byte-lane writes and unmapped addresses
    wb_write(4'd1, 32'h0000ABCD, 4'hF);
    wb_write(4'd1, 32'h00000012, 4'b0001);
    rd_chk("lane_high", 4'd1, 32'h0000AB12);
    wb_write(4'd7, 32'hFFFFFFFF, 4'hF);
    rd_chk("unmapped", 4'd7, 32'h0);

    // Reset in the middle of a high phase
    wb_write(4'd1, 32'd10, 4'hF);
    wb_write(4'd3, 32'd0, 4'hF);
    wb_write(4'd0, 32'h1, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_high", {31'd0, pulse}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_pulse", {31'd0, pulse}, 32'd0);
    rst_n = 1'b1;
    rd_chk("midrst_high_reg", 4'd1, 32'd0);
    rd_chk("midrst_ctrl", 4'd0, 32'd0);

`ifdef TDC_PULSEGEN_JITTER_EN
    begin
      int d;
      wb_write(4'd5, 32'h7, 4'hF);
      rd_chk("jmask_rd", 4'd5, 32'h7);
      wb_write(4'd1, 32'd1, 4'hF);
      wb_write(4'd2, 32'd1, 4'hF);
      wb_write(4'd3, 32'd100, 4'hF);
      wb_write(4'd0, 32'h1, 4'hF);
      measure_lows(1, 8, d);
      chk("jit_distinct", {31'd0, d > 1}, 32'd1);
      repeat (3) @(negedge clk);
      rd_chk("jit_done", 4'd0, 32'h8);
      wb_write(4'd5, 32'h0, 4'hF);
      wb_write(4'd0, 32'h1, 4'hF);
      measure_lows(1, 1, d);
      chk("nojit_distinct", d, 1);
      repeat (3) @(negedge clk);
    end
`else
    wb_write(4'd5, 32'h7, 4'hF);
    rd_chk("jmask_absent", 4'd5, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
